// File: rtl/chiaxung_ctrl.sv
// chiaxung_ctrl: run-time controller for the pulse divider.
// Sequences start/stop/one-shot operation and accepts new divide ratios
// through a valid/ready handshake. While running, a new ratio waits in a
// shadow register and is applied only at a period boundary, so clko and
// tick never glitch.
//
// state | meaning
// IDLE  | stopped; counter parked at 0; config loads directly
// RUN   | counting; tick at end of each period; config goes to shadow
// DONE  | one-shot period finished; waiting for en to drop
module chiaxung_ctrl #(
   parameter int CNT_W       = 27,
   parameter int DEFAULT_DIV = 100000000
) (
   input  logic             clki,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic             cfg_oneshot,
   output logic             cfg_ready,
   output logic             clko,
   output logic             tick,
   output logic             busy,
   output logic [15:0]      tick_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_div_q;
   logic [CNT_W-1:0] w_div_nxt;
   logic             r_oneshot_q;
   logic             w_oneshot_nxt;
   logic [CNT_W-1:0] r_shadow_div;
   logic [CNT_W-1:0] w_shadow_div_nxt;
   logic             r_shadow_oneshot;
   logic             w_shadow_oneshot_nxt;
   logic             r_pending;
   logic             w_pending_nxt;
   logic [15:0]      r_tick_cnt;
   logic [15:0]      w_tick_cnt_nxt;

   logic             w_tick;
   logic             w_xfer;
   logic [CNT_W-1:0] w_cfg_div;

   // A ratio of 0 is meaningless, so it is treated as divide-by-1.
   assign w_cfg_div = (cfg_div == '0) ? ONE : cfg_div;
   assign w_xfer    = cfg_valid && !r_pending;
   assign w_tick    = (r_state == ST_RUN) && (r_cnt == (r_div_q - ONE));

   assign cfg_ready = !r_pending;
   assign tick      = w_tick;
   assign busy      = (r_state == ST_RUN);
   assign clko      = (r_state == ST_RUN) && (r_cnt >= (r_div_q >> 1));
   assign tick_cnt  = r_tick_cnt;

   // Next-state, counter and config-path decode.
   always_comb begin
      w_state_nxt          = r_state;
      w_cnt_nxt            = r_cnt;
      w_div_nxt            = r_div_q;
      w_oneshot_nxt        = r_oneshot_q;
      w_shadow_div_nxt     = r_shadow_div;
      w_shadow_oneshot_nxt = r_shadow_oneshot;
      w_pending_nxt        = r_pending;
      w_tick_cnt_nxt       = r_tick_cnt;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_xfer) begin
               w_div_nxt     = w_cfg_div;
               w_oneshot_nxt = cfg_oneshot;
            end
            if (en) begin
               w_state_nxt    = ST_RUN;
               w_tick_cnt_nxt = '0;
            end
         end
         ST_RUN: begin
            if (w_tick) begin
               w_cnt_nxt      = '0;
               w_tick_cnt_nxt = r_tick_cnt + 16'd1;
            end else begin
               w_cnt_nxt = r_cnt + ONE;
            end
            if (w_xfer) begin
               w_shadow_div_nxt     = w_cfg_div;
               w_shadow_oneshot_nxt = cfg_oneshot;
               w_pending_nxt        = 1'b1;
            end
            // The oneshot decision uses the ratio/mode of the period ending now.
            if (!en) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (w_tick && r_oneshot_q) begin
               w_state_nxt = ST_DONE;
            end
            // Every exit from RUN coincides with a tick or !en, so a pending
            // shadow never survives into IDLE or DONE.
            if (r_pending && (w_tick || !en)) begin
               w_div_nxt     = r_shadow_div;
               w_oneshot_nxt = r_shadow_oneshot;
               w_pending_nxt = 1'b0;
            end
         end
         ST_DONE: begin
            w_cnt_nxt = '0;
            if (w_xfer) begin
               w_div_nxt     = w_cfg_div;
               w_oneshot_nxt = cfg_oneshot;
            end
            if (!en) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any period immediately.
   always_ff @(posedge clki or posedge rst) begin
      if (rst) begin
         r_state          <= ST_IDLE;
         r_cnt            <= '0;
         r_div_q          <= DIV_RST;
         r_oneshot_q      <= 1'b0;
         r_shadow_div     <= DIV_RST;
         r_shadow_oneshot <= 1'b0;
         r_pending        <= 1'b0;
         r_tick_cnt       <= '0;
      end else begin
         r_state          <= w_state_nxt;
         r_cnt            <= w_cnt_nxt;
         r_div_q          <= w_div_nxt;
         r_oneshot_q      <= w_oneshot_nxt;
         r_shadow_div     <= w_shadow_div_nxt;
         r_shadow_oneshot <= w_shadow_oneshot_nxt;
         r_pending        <= w_pending_nxt;
         r_tick_cnt       <= w_tick_cnt_nxt;
      end
   end

endmodule
